arb_mux_4_1: RTL

Round-robin arbitrated 4:1 channel selector with a registered, valid/ready-handshaked output. Four producers each present a word with a valid flag. The block picks one fairly, routes it through the existing `mux_4_1` combinational selector, and holds the result in a single output register for the downstream consumer. It sits directly upstream of any consumer of a 4:1 multiplexed stream and generates the `sel` that drives `mux_4_1`.

---
 rtl/arb_mux_pkg.sv | 8 +
 rtl/arb_mux_4_1_mux.sv | 27 ++
 rtl/arb_mux_4_1.sv | 72 +++++++
 3 files changed

// File: rtl/arb_mux_pkg.sv
// Shared types and constants for the round-robin arbitrated 4:1 selector.
`timescale 1ns/1ps
package arb_mux_pkg;
  localparam int WIDTH = 4;
  localparam int N_CH  = 4;

  typedef logic [1:0] ch_idx_t;
endpackage

// File: rtl/arb_mux_4_1_mux.sv
// Combinational 4:1 word selector; sel picks which input appears on y.
`timescale 1ns/1ps
module mux_4_1
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = arb_mux_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  ch_idx_t          sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d0;
    case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/arb_mux_4_1.sv
// Round-robin arbiter feeding a single registered valid/ready output stage.
`timescale 1ns/1ps
module arb_mux_4_1
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = arb_mux_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [3:0]       in_vld,
  output logic [3:0]       in_rdy,
  output logic [WIDTH-1:0] out_data,
  output ch_idx_t          out_sel,
  output logic             out_vld,
  input  logic             out_rdy
);

  ch_idx_t          ptr;
  ch_idx_t          grant;
  logic             load;
  logic [WIDTH-1:0] mux_y;

  // Scan ptr, ptr+1, ... (mod 4); the first requester found wins.
  always_comb begin
    ch_idx_t idx;
    logic    found;
    grant = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < N_CH; k++) begin
      idx = ptr + ch_idx_t'(k);
      if (!found && in_vld[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  assign load   = (|in_vld) & (~out_vld | out_rdy);
  assign in_rdy = load ? (4'b0001 << grant) : 4'b0000;

  mux_4_1 #(.WIDTH(WIDTH)) u_mux (
    .d0  (d0),
    .d1  (d1),
    .d2  (d2),
    .d3  (d3),
    .sel (grant),
    .y   (mux_y)
  );

  // Output register: load has priority over a plain drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_sel  <= '0;
      ptr      <= '0;
    end else if (load) begin
      out_vld  <= 1'b1;
      out_data <= mux_y;
      out_sel  <= grant;
      ptr      <= grant + ch_idx_t'(1);
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

endmodule
